// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the MEM-stage port (0)
// and the write-buffer/auxiliary port (1); holds each transaction until ready or timeout.
module sram_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_read_en,
  input  logic        p0_write_en,
  input  logic [18:0] p0_address,
  input  logic [31:0] p0_write_data,
  output logic [63:0] p0_read_data,
  output logic        p0_ack,
  input  logic        p1_read_en,
  input  logic        p1_write_en,
  input  logic [18:0] p1_address,
  input  logic [31:0] p1_write_data,
  output logic [63:0] p1_read_data,
  output logic        p1_ack,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [18:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
  logic [7:0]  count_q, count_d;

  logic p0_req, p1_req, winner, win_read;

  assign p0_req = p0_read_en | p0_write_en;
  assign p1_req = p1_read_en | p1_write_en;

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    terr_d       = terr_q;
    count_d      = count_q;
    winner       = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    win_read     = winner ? p1_read_en : p0_read_en;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d = winner;
          rd_en_d = win_read;
          wr_en_d = ~win_read;
          addr_d  = winner ? p1_address : p0_address;
          wdata_d = winner ? p1_write_data : p0_write_data;
          count_d = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // count_q == 0 marks the first BUSY cycle, where ready is not yet meaningful
        if (sram_ready && count_q != 8'd0) begin
          if (rd_en_q && !grant_q) rdata0_d = sram_read_data;
          if (rd_en_q && grant_q)  rdata1_d = sram_read_data;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = RESP;
        end else if (count_q == LAST_COUNT) begin
          terr_d  = 1'b1;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = RESP;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      count_q      <= count_d;
    end
  end

  assign sram_read_en    = rd_en_q;
  assign sram_write_en   = wr_en_q;
  assign sram_address    = addr_q;
  assign sram_write_data = wdata_q;
  assign p0_read_data    = rdata0_q;
  assign p1_read_data    = rdata1_q;
  assign p0_ack          = ack0_q;
  assign p1_ack          = ack1_q;
  assign grant           = grant_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the single SRAM controller between two requesters:
  - port 0: MEM-stage data access path.
  - port 1: write-buffer / auxiliary master.
- Arbitrates round-robin and drives the controller's enable/address/data handshake.
- Holds the granted transaction until the controller signals completion, returns read data, and pulses a per-port acknowledge.
- Sits directly upstream of the SRAM controller; the controller itself is unchanged.

## Interface
- TIMEOUT, 64: maximum cycles in BUSY before abort; 8-bit counter, legal 2..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- p0_read_en, p0_write_en  in  1 each  port-0 request (level).
- p0_address  in  19  port-0 byte address.
- p0_write_data  in  32  port-0 store data.
- p0_read_data  out  64  port-0 returned read data.
- p0_ack  out  1  port-0 one-cycle completion pulse.
- p1_read_en, p1_write_en, p1_address, p1_write_data, p1_read_data, p1_ack: identical for port 1.
- sram_read_en, sram_write_en  out  1 each  to controller read_en/write_en.
- sram_address  out  19  to controller address.
- sram_write_data  out  32  to controller writeData.
- sram_read_data  in  64  from controller readData.
- sram_ready  in  1  from controller ready.
- grant  out  1  port currently owning the controller; valid in BUSY/RESP.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky; set on any timeout abort.

## Operation
- States: IDLE, BUSY, RESP.
- Port request: a port requests when read_en | write_en.
- Both read_en and write_en high on one port: treated as a read; the write is ignored.
- IDLE:
  - If any request is pending, pick a winner:
    - Only one requesting: that port wins.
    - Both requesting: the port != last_grant wins.
  - Latch winner, op, address and write data into registers; clear wait counter; go to BUSY.
  - With no request pending, stay in IDLE.
- BUSY:
  - sram_read_en/sram_write_en driven from the latched op; address and data held stable.
  - Wait counter increments each cycle.
  - sram_ready == 1 sampled: capture sram_read_data into the granted port's read_data register (reads only); go to RESP.
  - Wait counter reaches TIMEOUT-1 without ready: set timeout_err, leave read_data unchanged, go to RESP.
- RESP:
  - Granted port's ack = 1, all enables 0.
  - last_grant <= grant; go to IDLE.
- Requester rule: hold request, address and data stable until the ack cycle; deassert by the first cycle after ack. A request still high in that IDLE cycle is a new transaction.
- A deasserted request during BUSY is ignored: the transaction completes and ack still fires.
- Read data is retained per port until that port's next completed read.
- timeout_err clears only on reset.

## Timing
- All outputs are registered.
- Reset values (rst low at an edge): state IDLE, all enables 0, acks 0, busy 0, grant 0, last_grant 1 (port 0 wins the first tie), read_data 0, sram_address 0, sram_write_data 0, timeout_err 0.
- Reset mid-transaction: enables drop on the next edge; the outstanding request is dropped with no ack.
- Request seen in IDLE at edge t:
  - Enable is high from cycle t+1.
  - Ready sampled high at edge t+k: enable is low and ack is high in cycle t+k+1.
  - Cycle t+k+2 is IDLE.
  - Earliest next enable is t+k+3.
- Enable drops on the same edge the controller leaves its completion state, so the controller never sees a spurious second request.
- sram_ready is only evaluated in BUSY; a high value in IDLE (controller idle indication) is ignored.
- The first BUSY cycle's sram_ready is also ignored: the controller's ready is combinational and low there.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…; the maximum wait is one foreign transaction.

## Test plan
- Single read, port 0:
  - Stimulus: p0_read_en=1, p0_address=0x00410; controller model returns 64'hDEAD_BEEF_0123_4567 after 4 BUSY cycles.
  - Required: sram_read_en high for exactly 4 cycles, then p0_ack for 1 cycle with p0_read_data=64'hDEAD_BEEF_0123_4567; p1_ack stays 0.
- Single write, port 1:
  - Stimulus: p1_write_en=1, address 0x00420, data 0xCAFEF00D.
  - Required: sram_write_en high, sram_address=0x00420 and sram_write_data=0xCAFEF00D stable through BUSY; p1_ack one pulse; p1_read_data unchanged.
- Simultaneous requests from reset, both held for 4 transactions:
  - Required: grant order 0,1,0,1; each ack exactly once per transaction; enables never high in RESP or IDLE.
- Both read_en and write_en on port 0:
  - Required: sram_read_en=1, sram_write_en=0 for the whole transaction.
- Timeout with TIMEOUT=8 and sram_ready held 0:
  - Required: enable drops after 8 BUSY cycles; ack pulses; timeout_err=1 and stays 1 through later good transactions until rst=0.
- Reset mid-transaction:
  - Stimulus: rst=0 in the 3rd BUSY cycle.
  - Required: next cycle all enables 0, busy 0, no ack, timeout_err 0.
  - Required after release: a pending p1 request is granted first.
